// File: rtl/soc_network_adapter_configuration_reader.sv
`default_nettype none
// ============================================================================
// Module   : soc_network_adapter_configuration_reader
// Purpose  : Walks the read-only network adapter configuration space after
//            reset or on request, caches every scalar register and presents
//            the values as flat outputs. The configuration port is shared
//            with other masters through a request/grant handshake.
// Options  : OPTIMSOC_NA_CONF_READER_CTLIST_EN - when defined, also caches
//            the compute-tile list in a MAX_CTS x 16-bit table.
// Revision : 1.0 - initial release
// ============================================================================
module soc_network_adapter_configuration_reader #(
  parameter int DW        = 32,  // configuration bus width, only 32 is supported
  parameter int MAX_CTS   = 64,  // compute-tile list capacity (1..64)
  parameter int AUTOSTART = 1    // 1: start a scan right after reset release
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          valid,
  output logic          error,
  output logic [15:0]   cfg_addr,
  output logic          cfg_en,
  output logic          cfg_we,
  output logic [DW-1:0] cfg_wdata,
  input  logic          cfg_gnt,
  input  logic [DW-1:0] cfg_rdata,
  output logic [31:0]   tile_id,
  output logic [31:0]   num_tiles,
  output logic [31:0]   core_base,
  output logic [31:0]   domain_numcores,
  output logic [31:0]   gmem_size,
  output logic [31:0]   gmem_tile,
  output logic [31:0]   lmem_size,
  output logic [31:0]   seed,
  output logic [6:0]    num_cts,
  output logic          conf_mpsimple,
  output logic          conf_dma,
  input  logic [5:0]    ct_query_idx,
  output logic [15:0]   ct_query_tile
);

  localparam logic [3:0]  C_LAST_STEP = 4'd9;       // seed is the tenth scalar read
  localparam logic [15:0] C_CT_BASE   = 16'h0200;   // first compute-tile list word

  // The list state only exists when the list cache is built.
`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCALAR = 2'd1,
    S_CTLIST = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCALAR = 2'd1,
    S_DONE   = 2'd3
  } state_t;
`endif

  // Byte address of each scalar register in scan order.
  function automatic logic [15:0] scalar_addr(input logic [3:0] step);
    case (step)
      4'd0:    scalar_addr = 16'h0000;  // tile_id
      4'd1:    scalar_addr = 16'h0004;  // num_tiles
      4'd2:    scalar_addr = 16'h000C;  // conf
      4'd3:    scalar_addr = 16'h0010;  // core_base
      4'd4:    scalar_addr = 16'h0018;  // domain_numcores
      4'd5:    scalar_addr = 16'h001C;  // gmem_size
      4'd6:    scalar_addr = 16'h0020;  // gmem_tile
      4'd7:    scalar_addr = 16'h0024;  // lmem_size
      4'd8:    scalar_addr = 16'h0028;  // numcts
      default: scalar_addr = 16'h002C;  // seed
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        cfg_en_q, cfg_en_d;
  logic [15:0] cfg_addr_q, cfg_addr_d;
  logic        auto_q, auto_d;
  logic [31:0] tile_id_q, tile_id_d;
  logic [31:0] num_tiles_q, num_tiles_d;
  logic [31:0] core_base_q, core_base_d;
  logic [31:0] domain_numcores_q, domain_numcores_d;
  logic [31:0] gmem_size_q, gmem_size_d;
  logic [31:0] gmem_tile_q, gmem_tile_d;
  logic [31:0] lmem_size_q, lmem_size_d;
  logic [31:0] seed_q, seed_d;
  logic [6:0]  num_cts_q, num_cts_d;
  logic [1:0]  conf_q, conf_d;

  // A read completes on any edge where the request is presented and granted.
  logic        rd_done;
  assign rd_done = cfg_en_q & cfg_gnt;

`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
  logic [5:0]  ct_idx_q, ct_idx_d;
  logic        tbl_wr_en;
  logic [15:0] tbl_wr_data;
  logic [15:0] tbl_q [MAX_CTS];
`endif

  // Next-state, bus request and cache capture logic.
  always_comb begin
    state_d           = state_q;
    step_d            = step_q;
    busy_d            = busy_q;
    valid_d           = valid_q;
    error_d           = error_q;
    cfg_en_d          = cfg_en_q;
    cfg_addr_d        = cfg_addr_q;
    auto_d            = auto_q;
    tile_id_d         = tile_id_q;
    num_tiles_d       = num_tiles_q;
    core_base_d       = core_base_q;
    domain_numcores_d = domain_numcores_q;
    gmem_size_d       = gmem_size_q;
    gmem_tile_d       = gmem_tile_q;
    lmem_size_d       = lmem_size_q;
    seed_d            = seed_q;
    num_cts_d         = num_cts_q;
    conf_d            = conf_q;
`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
    ct_idx_d          = ct_idx_q;
    tbl_wr_en         = 1'b0;
    tbl_wr_data       = 16'h0000;
`endif

    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d    = S_SCALAR;
          step_d     = 4'd0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          error_d    = 1'b0;
          cfg_en_d   = 1'b1;
          cfg_addr_d = scalar_addr(4'd0);
          auto_d     = 1'b0;
        end
      end

      S_SCALAR: begin
        if (rd_done) begin
          case (step_q)
            4'd0: tile_id_d         = cfg_rdata;
            4'd1: num_tiles_d       = cfg_rdata;
            4'd2: conf_d            = cfg_rdata[1:0];
            4'd3: core_base_d       = cfg_rdata;
            4'd4: domain_numcores_d = cfg_rdata;
            4'd5: gmem_size_d       = cfg_rdata;
            4'd6: gmem_tile_d       = cfg_rdata;
            4'd7: lmem_size_d       = cfg_rdata;
            4'd8: begin
              // Clamp an oversized tile count and flag it.
              if (cfg_rdata > DW'(MAX_CTS)) begin
                num_cts_d = 7'(MAX_CTS);
                error_d   = 1'b1;
              end else begin
                num_cts_d = cfg_rdata[6:0];
              end
            end
            default: seed_d = cfg_rdata;
          endcase

          if (step_q == C_LAST_STEP) begin
`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
            if (num_cts_q != 7'd0) begin
              state_d    = S_CTLIST;
              ct_idx_d   = 6'd0;
              cfg_addr_d = C_CT_BASE;
            end else begin
              state_d  = S_DONE;
              cfg_en_d = 1'b0;
            end
`else
            state_d  = S_DONE;
            cfg_en_d = 1'b0;
`endif
          end else begin
            step_d     = step_q + 4'd1;
            cfg_addr_d = scalar_addr(step_q + 4'd1);
          end
        end
      end

`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
      S_CTLIST: begin
        if (rd_done) begin
          // Two 16-bit entries share a word: even index in the upper half.
          tbl_wr_en   = 1'b1;
          tbl_wr_data = ct_idx_q[0] ? cfg_rdata[15:0] : cfg_rdata[31:16];
          if ({1'b0, ct_idx_q} == (num_cts_q - 7'd1)) begin
            state_d  = S_DONE;
            cfg_en_d = 1'b0;
          end else begin
            ct_idx_d   = ct_idx_q + 6'd1;
            cfg_addr_d = C_CT_BASE + {9'd0, ct_idx_q + 6'd1, 1'b0};
          end
        end
      end
`endif

      S_DONE: begin
        // Single-cycle state: publish the cache and fall back to idle.
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, bus request and cached scalar registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      step_q            <= 4'd0;
      busy_q            <= 1'b0;
      valid_q           <= 1'b0;
      error_q           <= 1'b0;
      cfg_en_q          <= 1'b0;
      cfg_addr_q        <= 16'h0000;
      auto_q            <= (AUTOSTART != 0);
      tile_id_q         <= 32'd0;
      num_tiles_q       <= 32'd0;
      core_base_q       <= 32'd0;
      domain_numcores_q <= 32'd0;
      gmem_size_q       <= 32'd0;
      gmem_tile_q       <= 32'd0;
      lmem_size_q       <= 32'd0;
      seed_q            <= 32'd0;
      num_cts_q         <= 7'd0;
      conf_q            <= 2'd0;
    end else begin
      state_q           <= state_d;
      step_q            <= step_d;
      busy_q            <= busy_d;
      valid_q           <= valid_d;
      error_q           <= error_d;
      cfg_en_q          <= cfg_en_d;
      cfg_addr_q        <= cfg_addr_d;
      auto_q            <= auto_d;
      tile_id_q         <= tile_id_d;
      num_tiles_q       <= num_tiles_d;
      core_base_q       <= core_base_d;
      domain_numcores_q <= domain_numcores_d;
      gmem_size_q       <= gmem_size_d;
      gmem_tile_q       <= gmem_tile_d;
      lmem_size_q       <= lmem_size_d;
      seed_q            <= seed_d;
      num_cts_q         <= num_cts_d;
      conf_q            <= conf_d;
    end
  end

`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
  // Compute-tile list cache and its write index.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct_idx_q <= 6'd0;
      for (int i = 0; i < MAX_CTS; i++) begin
        tbl_q[i] <= 16'h0000;
      end
    end else begin
      ct_idx_q <= ct_idx_d;
      if (tbl_wr_en) begin
        tbl_q[ct_idx_q] <= tbl_wr_data;
      end
    end
  end

  // Entries beyond the cached count, or while the cache is stale, read as 0.
  assign ct_query_tile = (valid_q && ({1'b0, ct_query_idx} < num_cts_q)) ?
                         tbl_q[ct_query_idx] : 16'h0000;
`else
  logic unused_ct_query;
  assign unused_ct_query = ^ct_query_idx;
  assign ct_query_tile   = 16'h0000;
`endif

  assign busy            = busy_q;
  assign valid           = valid_q;
  assign error           = error_q;
  assign cfg_en          = cfg_en_q;
  assign cfg_addr        = cfg_addr_q;
  assign cfg_we          = 1'b0;
  assign cfg_wdata       = '0;
  assign tile_id         = tile_id_q;
  assign num_tiles       = num_tiles_q;
  assign core_base       = core_base_q;
  assign domain_numcores = domain_numcores_q;
  assign gmem_size       = gmem_size_q;
  assign gmem_tile       = gmem_tile_q;
  assign lmem_size       = lmem_size_q;
  assign seed            = seed_q;
  assign num_cts         = num_cts_q;
  assign conf_mpsimple   = conf_q[0];
  assign conf_dma        = conf_q[1];

endmodule
`default_nettype wire

// File: tb/tb_soc_network_adapter_configuration_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_network_adapter_configuration_reader
// Purpose  : Scoreboard bench for the configuration reader. A memory model
//            answers configuration reads; expected read addresses and final
//            cache contents are queued when a scan is launched and a monitor
//            compares them as the DUT presents requests and raises valid.
// Options  : follows OPTIMSOC_NA_CONF_READER_CTLIST_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_network_adapter_configuration_reader;

  localparam int MAX_CTS = 64;
`ifdef OPTIMSOC_NA_CONF_READER_CTLIST_EN
  localparam bit LIST_EN = 1'b1;
`else
  localparam bit LIST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, busy, valid, error;
  logic [15:0] cfg_addr;
  logic        cfg_en, cfg_we, cfg_gnt;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [31:0] tile_id, num_tiles, core_base, domain_numcores;
  logic [31:0] gmem_size, gmem_tile, lmem_size, seed;
  logic [6:0]  num_cts;
  logic        conf_mpsimple, conf_dma;
  logic [5:0]  ct_query_idx;
  logic [15:0] ct_query_tile;

  soc_network_adapter_configuration_reader #(
    .DW(32), .MAX_CTS(MAX_CTS), .AUTOSTART(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .valid(valid),
    .error(error), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_we(cfg_we),
    .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt), .cfg_rdata(cfg_rdata),
    .tile_id(tile_id), .num_tiles(num_tiles), .core_base(core_base),
    .domain_numcores(domain_numcores), .gmem_size(gmem_size),
    .gmem_tile(gmem_tile), .lmem_size(lmem_size), .seed(seed),
    .num_cts(num_cts), .conf_mpsimple(conf_mpsimple), .conf_dma(conf_dma),
    .ct_query_idx(ct_query_idx), .ct_query_tile(ct_query_tile)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Configuration space model: word array for 0x00..0x2F, tile list above 0x200.
  logic [31:0] mem [12];
  logic [15:0] lst [64];

  function automatic logic [31:0] rd_model(input logic [15:0] a);
    int w;
    if (a < 16'h0030) return mem[a[5:2]];
    if (a >= 16'h0200 && a < 16'h0280) begin
      w = (int'(a) - 'h200) / 4;
      return {lst[2*w], lst[2*w+1]};
    end
    return 32'hDEAD_BEEF;
  endfunction

  always_comb cfg_rdata = rd_model(cfg_addr);

  typedef struct {
    logic [31:0] tile_id, num_tiles, core_base, dom, gsize, gtile, lsize, seed;
    logic [6:0]  n;
    logic        err;
    logic [1:0]  conf;
    int          lat;
  } exp_t;

  logic [15:0] exp_addr_q [$];
  exp_t        exp_res_q  [$];
  int          scan_e0 = 0;
  int          cur_n   = 0;
  bit          rand_gnt = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outcome of one scan computed from the register-space contents.
  task automatic push_scan(input int extra_lat);
    exp_t e;
    int   n;
    int   offs [10] = '{'h00, 'h04, 'h0C, 'h10, 'h18, 'h1C, 'h20, 'h24, 'h28, 'h2C};
    e.tile_id   = mem[0];
    e.num_tiles = mem[1];
    e.conf      = mem[3][1:0];
    e.core_base = mem[4];
    e.dom       = mem[6];
    e.gsize     = mem[7];
    e.gtile     = mem[8];
    e.lsize     = mem[9];
    e.seed      = mem[11];
    if (mem[10] > 32'(MAX_CTS)) begin
      n = MAX_CTS; e.err = 1'b1;
    end else begin
      n = int'(mem[10]); e.err = 1'b0;
    end
    e.n   = 7'(n);
    cur_n = n;
    for (int i = 0; i < 10; i++) exp_addr_q.push_back(16'(offs[i]));
    if (LIST_EN) for (int k = 0; k < n; k++) exp_addr_q.push_back(16'(32'h200 + 2*k));
    e.lat = (extra_lat < 0) ? -1 : 11 + (LIST_EN ? n : 0) + extra_lat;
    exp_res_q.push_back(e);
  endtask

  function automatic logic [15:0] exp_query(input int idx);
    return (LIST_EN && idx < cur_n) ? lst[idx] : 16'h0000;
  endfunction

  // Monitor: checks every presented request and the cache when valid rises.
  initial begin : monitor
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_en === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_read", {48'd0, cfg_addr}, 64'hFFFF_FFFF);
        end else begin
          chk("cfg_addr", {48'd0, cfg_addr}, {48'd0, exp_addr_q[0]});
          if (cfg_gnt) void'(exp_addr_q.pop_front());
        end
      end
      if (valid === 1'b1 && !pv) begin
        if (exp_res_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = exp_res_q.pop_front();
          chk("tile_id", tile_id, e.tile_id);
          chk("num_tiles", num_tiles, e.num_tiles);
          chk("core_base", core_base, e.core_base);
          chk("domain_numcores", domain_numcores, e.dom);
          chk("gmem_size", gmem_size, e.gsize);
          chk("gmem_tile", gmem_tile, e.gtile);
          chk("lmem_size", lmem_size, e.lsize);
          chk("seed", seed, e.seed);
          chk("num_cts", num_cts, e.n);
          chk("error", error, e.err);
          chk("conf_mpsimple", conf_mpsimple, e.conf[0]);
          chk("conf_dma", conf_dma, e.conf[1]);
          chk("busy_at_valid", busy, 0);
          if (e.lat >= 0) chk("latency", 64'(cyc - scan_e0), 64'(e.lat));
        end
      end
      pv = (valid === 1'b1);
    end
  end

  // Optional random grant pattern.
  initial begin : gnt_gen
    forever begin
      @(posedge clk);
      #2;
      if (rand_gnt) cfg_gnt = ($urandom_range(0, 3) != 0);
    end
  end

  // Called in the drive phase (just after a rising edge).
  task automatic do_start(input int extra_lat);
    push_scan(extra_lat);
    ct_query_idx = 6'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    scan_e0 = cyc;
    chk("valid_cleared_on_start", valid, 0);
    chk("busy_on_start", busy, 1);
    chk("query_while_stale", ct_query_tile, 0);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (!(valid === 1'b1 && exp_res_q.size() == 0 && busy === 1'b0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) begin
      checks++; errors++;
      $display("FAIL scan_timeout: got no valid within %0d cycles, required valid=1", lim);
      exp_addr_q.delete();
      exp_res_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic check_queries();
    int idx [5];
    idx[0] = 0;
    idx[1] = (cur_n > 0) ? cur_n - 1 : 0;
    idx[2] = (cur_n < 64) ? cur_n : 63;
    idx[3] = $urandom_range(0, 63);
    idx[4] = $urandom_range(0, 63);
    for (int i = 0; i < 5; i++) begin
      ct_query_idx = 6'(idx[i]);
      #1;
      chk($sformatf("ct_query[%0d]", idx[i]), ct_query_tile, exp_query(idx[i]));
    end
  endtask

  task automatic randomize_space(input logic [31:0] numcts);
    for (int i = 0; i < 12; i++) mem[i] = $urandom;
    mem[10] = numcts;
    for (int i = 0; i < 64; i++) lst[i] = 16'($urandom);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; cfg_gnt = 1'b1; ct_query_idx = 6'd0;
    randomize_space(32'd3);
    mem[0] = 32'd5;
    lst[0] = 16'd7; lst[1] = 16'd2; lst[2] = 16'd9;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_error", error, 0);
    chk("rst_cfg_en", cfg_en, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_tile_id", tile_id, 0);
    chk("rst_seed", seed, 0);
    chk("rst_num_cts", num_cts, 0);
    chk("rst_ct_query", ct_query_tile, 0);
    chk("cfg_we", cfg_we, 0);
    chk("cfg_wdata", cfg_wdata, 0);

    // Autostart after reset release, list {7,2,9}
    push_scan(0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 scan_e0 = cyc;
    #1;
    wait_done(200);
    check_queries();
    ct_query_idx = 6'd1; #1 chk("query_idx1", ct_query_tile, LIST_EN ? 16'd2 : 16'd0);
    ct_query_idx = 6'd3; #1 chk("query_idx3", ct_query_tile, 0);

    // Grant withheld for 4 cycles while 0x1C is requested
    randomize_space(32'd2);
    do_start(4);
    repeat (5) @(posedge clk);
    #2 cfg_gnt = 1'b0;
    repeat (4) @(posedge clk);
    #2 cfg_gnt = 1'b1;
    wait_done(200);
    check_queries();

    // Oversized tile count is clamped and flagged
    randomize_space(32'd100);
    do_start(0);
    wait_done(300);
    check_queries();

    // CONF bits set, empty tile list
    randomize_space(32'd0);
    mem[3] = 32'h3;
    do_start(0);
    wait_done(200);
    check_queries();

    // Reset during list entry 1 aborts the scan
    randomize_space(32'd5);
    do_start(0);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    ct_query_idx = 6'd1;
    @(posedge clk);
    #1;
    chk("abort_cfg_en", cfg_en, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ct_query", ct_query_tile, 0);
    chk("abort_tile_id", tile_id, 0);
    exp_addr_q.delete();
    exp_res_q.delete();
    push_scan(0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 scan_e0 = cyc;
    #1;
    wait_done(200);
    check_queries();

    // Start while busy is ignored; a later start rescans with a new seed
    randomize_space(32'd4);
    do_start(0);
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(200);
    mem[11] = $urandom;
    do_start(0);
    wait_done(200);
    check_queries();

    // Random register contents with a random grant pattern
    rand_gnt = 1'b1;
    for (int s = 0; s < 8; s++) begin
      randomize_space(($urandom_range(0, 3) == 0) ? 32'($urandom_range(65, 1000))
                                                  : 32'($urandom_range(0, 64)));
      do_start(-1);
      wait_done(1000);
      check_queries();
    end
    rand_gnt = 1'b0;
    cfg_gnt  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("addr_queue_drained", 64'(exp_addr_q.size()), 0);
    chk("result_queue_drained", 64'(exp_res_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
